control_unit: RTL and testbench

Multi-cycle control unit for the ezRISC CPU; it drives every control input of `datapath` (register enables, bus-out selects, ALU op, memory read strobe) one T-state at a time. It replaces the hand-sequenced control of the datapath bench. It reads the datapath IR and a memory-ready handshake, and runs fetch/decode/execute for register-format ALU, multiply/divide, unary, move-from-HI/LO, nop and halt instructions.

---
 rtl/ezrisc_pkg.sv | 63 ++++++
 rtl/reg_decoder.sv | 13 +
 rtl/control_unit.sv | 206 ++++++++++++++++++++
 tb/tb_control_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ezrisc_pkg.sv
// Shared definitions for the ezRISC control path: opcodes, ALU operation codes,
// control-unit state encoding and IR field positions.
package ezrisc_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_ROR = 4'b0110;
  localparam logic [3:0] ALU_ROL = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_DIV = 4'b1001;
  localparam logic [3:0] ALU_NEG = 4'b1010;
  localparam logic [3:0] ALU_NOT = 4'b1011;

  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_HALT
  } state_t;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    logic [3:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_SHR:  code = ALU_SHR;
      OP_SHL:  code = ALU_SHL;
      OP_ROR:  code = ALU_ROR;
      OP_ROL:  code = ALU_ROL;
      OP_OR:   code = ALU_OR;
      OP_MUL:  code = ALU_MUL;
      OP_DIV:  code = ALU_DIV;
      OP_NEG:  code = ALU_NEG;
      OP_NOT:  code = ALU_NOT;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/reg_decoder.sv
// Register-field to one-hot select decoder; all zeros when disabled.
module reg_decoder (
  input  logic        i_en,
  input  logic [3:0]  i_sel,
  output logic [15:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle ezRISC control unit: sequences fetch/decode/execute one T-state per
// cycle and drives every datapath strobe as a Moore function of state and IR.
module control_unit
  import ezrisc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic [15:0] gpr_in,
  output logic [15:0] gpr_out,
  output logic        hi_in,
  output logic        hi_out,
  output logic        lo_in,
  output logic        lo_out,
  output logic        pc_out,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        read,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        z_low_out,
  output logic        z_high_out,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal,
  output logic        mem_err
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_wait;
  logic [CW-1:0] w_wait_nxt;
  logic          r_mem_err;
  logic          w_err_set;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  logic       w_alu3, w_muldiv, w_unary, w_known;
  logic [3:0] w_out_sel;
  logic       w_out_en, w_in_en;
  logic       w_unused_ir;

  assign w_op        = ir[IR_OP_LSB +: 5];
  assign w_ra        = ir[IR_RA_LSB +: 4];
  assign w_rb        = ir[IR_RB_LSB +: 4];
  assign w_rc        = ir[IR_RC_LSB +: 4];
  assign w_unused_ir = ^ir[IR_RC_LSB-1:0];

  assign w_alu3   = w_op inside {OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_AND, OP_OR};
  assign w_muldiv = w_op inside {OP_MUL, OP_DIV};
  assign w_unary  = w_op inside {OP_NEG, OP_NOT};
  assign w_known  = w_alu3 | w_muldiv | w_unary |
                    (w_op inside {OP_MFHI, OP_MFLO, OP_NOP, OP_HALT});

  assign mem_err = r_mem_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_RST;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_nxt;
      if (w_err_set) r_mem_err <= 1'b1;
    end
  end

  // Next state plus every strobe; mem_rdy only steers the next state, never an output.
  always_comb begin
    w_next     = r_state;
    w_wait_nxt = '0;
    w_err_set  = 1'b0;
    w_out_en   = 1'b0;
    w_out_sel  = 4'd0;
    w_in_en    = 1'b0;
    hi_in      = 1'b0;
    hi_out     = 1'b0;
    lo_in      = 1'b0;
    lo_out     = 1'b0;
    pc_out     = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    read       = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    z_low_out  = 1'b0;
    z_high_out = 1'b0;
    alu_op     = ALU_AND;
    illegal    = 1'b0;
    run        = r_state inside {ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6};

    case (r_state)
      ST_RST: w_next = ST_T0;
      ST_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        w_next = ST_T1;
      end
      ST_T1: begin
        read   = 1'b1;
        mdr_in = 1'b1;
        // A ready seen on the final allowed cycle still wins over the timeout.
        if (mem_rdy) begin
          w_next = ST_T2;
        end else if (r_wait == CW'(MEM_WAIT_MAX)) begin
          w_next    = ST_HALT;
          w_err_set = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 1'b1;
        end
      end
      ST_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
        w_next  = ST_T3;
      end
      ST_T3: begin
        w_next = ST_T0;
        if (w_alu3) begin
          w_out_en  = 1'b1;
          w_out_sel = w_rb;
          y_in      = 1'b1;
          w_next    = ST_T4;
        end else if (w_muldiv) begin
          w_out_en  = 1'b1;
          w_out_sel = w_ra;
          y_in      = 1'b1;
          w_next    = ST_T4;
        end else if (w_unary) begin
          w_out_en  = 1'b1;
          w_out_sel = w_rb;
          z_in      = 1'b1;
          alu_op    = alu_code(w_op);
          w_next    = ST_T4;
        end else if (w_op == OP_MFHI) begin
          hi_out  = 1'b1;
          w_in_en = 1'b1;
        end else if (w_op == OP_MFLO) begin
          lo_out  = 1'b1;
          w_in_en = 1'b1;
        end else if (w_op == OP_HALT) begin
          w_next = ST_HALT;
        end else begin
          illegal = !w_known;
        end
      end
      ST_T4: begin
        w_next = ST_T0;
        if (w_alu3 || w_muldiv) begin
          w_out_en  = 1'b1;
          w_out_sel = w_alu3 ? w_rc : w_rb;
          z_in      = 1'b1;
          alu_op    = alu_code(w_op);
          w_next    = ST_T5;
        end else if (w_unary) begin
          z_low_out = 1'b1;
          w_in_en   = 1'b1;
        end
      end
      ST_T5: begin
        w_next = ST_T0;
        if (w_muldiv) begin
          z_low_out = 1'b1;
          lo_in     = 1'b1;
          w_next    = ST_T6;
        end else if (w_alu3) begin
          z_low_out = 1'b1;
          w_in_en   = 1'b1;
        end
      end
      ST_T6: begin
        z_high_out = 1'b1;
        hi_in      = 1'b1;
        w_next     = ST_T0;
      end
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_RST;
    endcase
  end

  reg_decoder u_out_dec (
    .i_en    (w_out_en),
    .i_sel   (w_out_sel),
    .o_onehot(gpr_out)
  );

  reg_decoder u_in_dec (
    .i_en    (w_in_en),
    .i_sel   (w_ra),
    .o_onehot(gpr_in)
  );

endmodule

// File: tb/tb_control_unit.sv
// Randomised bench for control_unit: an instruction-level model expands each
// instruction into its expected per-cycle strobe pattern and compares every cycle.
module tb_control_unit;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir;
  logic        mem_rdy;
  logic [15:0] gpr_in, gpr_out;
  logic        hi_in, hi_out, lo_in, lo_out, pc_out, inc_pc, mar_in;
  logic        mdr_in, mdr_out, rd, ir_in, y_in, z_in, z_low_out, z_high_out;
  logic [3:0]  alu_op;
  logic        run, illegal, mem_err;

  always #5 clk = ~clk;

  control_unit #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .mem_rdy(mem_rdy),
    .gpr_in(gpr_in), .gpr_out(gpr_out),
    .hi_in(hi_in), .hi_out(hi_out), .lo_in(lo_in), .lo_out(lo_out),
    .pc_out(pc_out), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .read(rd),
    .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .z_low_out(z_low_out), .z_high_out(z_high_out),
    .alu_op(alu_op), .run(run), .illegal(illegal), .mem_err(mem_err)
  );

  typedef struct packed {
    logic [15:0] gpr_in;
    logic [15:0] gpr_out;
    logic hi_in, hi_out, lo_in, lo_out, pc_out, inc_pc, mar_in;
    logic mdr_in, mdr_out, rd, ir_in, y_in, z_in, z_low_out, z_high_out;
    logic [3:0] alu_op;
    logic run, illegal, mem_err;
  } ctrl_t;

  typedef struct {
    ctrl_t       c;
    logic [31:0] irv;
    bit          rdy;
    int          ph;
    int          idx;
  } step_t;

  ctrl_t act;
  assign act = {gpr_in, gpr_out, hi_in, hi_out, lo_in, lo_out, pc_out, inc_pc, mar_in,
                mdr_in, mdr_out, rd, ir_in, y_in, z_in, z_low_out, z_high_out,
                alu_op, run, illegal, mem_err};

  step_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    n_instr = 0;
  string PH[9] = '{"RST", "T0", "T1", "T2", "T3", "T4", "T5", "T6", "HALT"};

  task automatic chk(input string tag, input logic [53:0] got, input logic [53:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctrl_t base();
    ctrl_t c = '0;
    c.run = 1'b1;
    return c;
  endfunction

  function automatic logic [3:0] alu_of(input logic [4:0] op);
    case (op)
      5'd3:  return 4'b0010;
      5'd4:  return 4'b0011;
      5'd5:  return 4'b0100;
      5'd6:  return 4'b0101;
      5'd7:  return 4'b0110;
      5'd8:  return 4'b0111;
      5'd9:  return 4'b0000;
      5'd10: return 4'b0001;
      5'd14: return 4'b1000;
      5'd15: return 4'b1001;
      5'd16: return 4'b1010;
      5'd17: return 4'b1011;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic push(input ctrl_t c, input logic [31:0] irv, input bit rdy, input int ph);
    step_t s;
    s.c = c; s.irv = irv; s.rdy = rdy; s.ph = ph; s.idx = n_instr;
    q.push_back(s);
  endtask

  // Expand one instruction into expected cycles; lo_cycles = T1 cycles with mem_rdy low.
  task automatic add_instr(input logic [31:0] irv, input int lo_cycles);
    logic [4:0]  op;
    logic [15:0] ra1, rb1, rc1;
    ctrl_t c;
    bit stop, err;
    op  = irv[31:27];
    ra1 = 16'(1) << irv[26:23];
    rb1 = 16'(1) << irv[22:19];
    rc1 = 16'(1) << irv[18:15];
    stop = 0; err = 0;
    n_instr++;
    c = base(); c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1;
    push(c, irv, 1'($urandom_range(0, 1)), 1);
    c = base(); c.rd = 1; c.mdr_in = 1;
    if (lo_cycles > MAXW) begin
      for (int i = 0; i <= MAXW; i++) push(c, irv, 1'b0, 2);
      stop = 1; err = 1;
    end else begin
      for (int i = 0; i < lo_cycles; i++) push(c, irv, 1'b0, 2);
      push(c, irv, 1'b1, 2);
    end
    if (!stop) begin
      c = base(); c.mdr_out = 1; c.ir_in = 1;
      push(c, irv, 1'($urandom_range(0, 1)), 3);
      if (op >= 5'd3 && op <= 5'd10) begin
        c = base(); c.gpr_out = rb1; c.y_in = 1; push(c, irv, 1'($urandom_range(0, 1)), 4);
        c = base(); c.gpr_out = rc1; c.z_in = 1; c.alu_op = alu_of(op);
        push(c, irv, 1'($urandom_range(0, 1)), 5);
        c = base(); c.z_low_out = 1; c.gpr_in = ra1; push(c, irv, 1'($urandom_range(0, 1)), 6);
      end else if (op == 5'd14 || op == 5'd15) begin
        c = base(); c.gpr_out = ra1; c.y_in = 1; push(c, irv, 1'($urandom_range(0, 1)), 4);
        c = base(); c.gpr_out = rb1; c.z_in = 1; c.alu_op = alu_of(op);
        push(c, irv, 1'($urandom_range(0, 1)), 5);
        c = base(); c.z_low_out = 1; c.lo_in = 1; push(c, irv, 1'($urandom_range(0, 1)), 6);
        c = base(); c.z_high_out = 1; c.hi_in = 1; push(c, irv, 1'($urandom_range(0, 1)), 7);
      end else if (op == 5'd16 || op == 5'd17) begin
        c = base(); c.gpr_out = rb1; c.z_in = 1; c.alu_op = alu_of(op);
        push(c, irv, 1'($urandom_range(0, 1)), 4);
        c = base(); c.z_low_out = 1; c.gpr_in = ra1; push(c, irv, 1'($urandom_range(0, 1)), 5);
      end else if (op == 5'd23) begin
        c = base(); c.hi_out = 1; c.gpr_in = ra1; push(c, irv, 1'($urandom_range(0, 1)), 4);
      end else if (op == 5'd24) begin
        c = base(); c.lo_out = 1; c.gpr_in = ra1; push(c, irv, 1'($urandom_range(0, 1)), 4);
      end else if (op == 5'd25) begin
        push(base(), irv, 1'($urandom_range(0, 1)), 4);
      end else if (op == 5'd26) begin
        push(base(), irv, 1'($urandom_range(0, 1)), 4);
        stop = 1;
      end else begin
        c = base(); c.illegal = 1; push(c, irv, 1'($urandom_range(0, 1)), 4);
      end
    end
    if (stop) begin
      c = '0; c.mem_err = err;
      for (int i = 0; i < 4; i++) push(c, irv, 1'($urandom_range(0, 1)), 8);
    end
  endtask

  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(posedge clk);
      #1;
      ir      = s.irv;
      mem_rdy = s.rdy;
      @(negedge clk);
      chk($sformatf("i%0d_%s", s.idx, PH[s.ph]), act, s.c);
    end
  endtask

  // Called at a falling edge; reset takes effect without waiting for a clock.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    chk({tag, "_async"}, act, '0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_held"}, act, '0);
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_halt);
    logic [31:0] r;
    logic [4:0]  op;
    r  = $urandom();
    op = 5'($urandom_range(0, 31));
    if (!allow_halt && op == 5'd26) op = 5'd25;
    return {op, r[26:0]};
  endfunction

  initial begin
    reset_n = 1'b0;
    ir      = '0;
    mem_rdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", act, '0);
    reset_n = 1'b1;

    add_instr(32'h4A920000, 0);
    add_instr(32'h18918000, 0);
    add_instr(32'h73380000, 0);
    add_instr(rand_instr(0), 3);
    add_instr(rand_instr(0), MAXW);
    run_q();

    for (int k = 0; k < 150; k++) add_instr(rand_instr(0), $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0);
    run_q();

    add_instr(32'hD0000000, 0);
    run_q();
    do_reset("halt_rst");

    add_instr(rand_instr(0), MAXW + 1);
    run_q();
    do_reset("tmo_rst");

    add_instr(32'hF8000000, 0);
    add_instr(32'hC8000000, 0);
    run_q();

    add_instr(32'h4A920000, 0);
    while (q.size() > 5) void'(q.pop_back());
    run_q();
    do_reset("abort_t4");
    add_instr(32'h18918000, 0);
    run_q();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
